// File: rtl/ray_dispatch_pkg.sv
// Shared types and helpers for the ray dispatcher.
//   dispatch_state_t  : frame-level scheduler states
//   unit_index_width  : bits needed to index N ray units (never less than 1)
package ray_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } dispatch_state_t;

  // $clog2(1) is 0, which would give a zero-width index bus.
  function automatic int unit_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ray_dispatcher_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req_i         : request vector, one bit per unit
//   ptr_i         : highest-priority index this cycle
//   grant_o       : one-hot grant (all zero when nothing requests)
//   grant_idx_o   : index of the granted unit
//   grant_valid_o : some request was granted
module rr_arbiter
  import ray_dispatch_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = unit_index_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_valid_o
);

  int   cand_s;
  logic found_s;

  // Walk the units starting at the pointer, wrapping, and keep the first requester.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found_s     = 1'b0;
    cand_s      = 0;
    for (int i = 0; i < N; i++) begin
      cand_s = (int'(ptr_i) + i) % N;
      if (!found_s && req_i[cand_s[IW-1:0]]) begin
        grant_o[cand_s[IW-1:0]] = 1'b1;
        grant_idx_o             = cand_s[IW-1:0];
        found_s                 = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    grant_valid_o = found_s;
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Frame-level scheduler feeding a bank of ray units.
// Rays arrive on a valid/ready stream into a one-entry buffer and are issued
// to ready units in round-robin order; all units are flushed at frame start
// and the frame completes once every ray is issued and every unit is idle.
//   clock, reset               : clock, asynchronous active-low reset
//   frameStart, frameRays      : begin a frame of frameRays rays (IDLE only)
//   frameBusy, frameDone       : frame in progress / one-cycle completion pulse
//   flush                      : one-cycle flush pulse to all units
//   rayValid, rayReady         : input ray handshake
//   inRayQ, inRayV, inPixelAddress : input ray position, direction, pixel
//   unitStart                  : one-hot start (combinational with the grant)
//   unitReady, unitBusy        : per-unit status
//   rayQ, rayV, pixelAddress   : shared ray bus (buffer contents)
//   dispatchCount              : rays issued in the current frame
module ray_dispatcher
  import ray_dispatch_pkg::*;
#(
  parameter int N_UNITS        = 4,
  parameter int POSITION_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int COUNT_WIDTH    = 20
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frameStart,
  input  logic [COUNT_WIDTH-1:0]      frameRays,
  output logic                        frameBusy,
  output logic                        frameDone,
  output logic                        flush,
  input  logic                        rayValid,
  output logic                        rayReady,
  input  logic [3*POSITION_WIDTH-1:0] inRayQ,
  input  logic [3*POSITION_WIDTH-1:0] inRayV,
  input  logic [ADDRESS_WIDTH-1:0]    inPixelAddress,
  output logic [N_UNITS-1:0]          unitStart,
  input  logic [N_UNITS-1:0]          unitReady,
  input  logic [N_UNITS-1:0]          unitBusy,
  output logic [3*POSITION_WIDTH-1:0] rayQ,
  output logic [3*POSITION_WIDTH-1:0] rayV,
  output logic [ADDRESS_WIDTH-1:0]    pixelAddress,
  output logic [COUNT_WIDTH-1:0]      dispatchCount
);

  localparam int IW = unit_index_width(N_UNITS);
  localparam int RW = 3 * POSITION_WIDTH;

  dispatch_state_t          state_q;
  logic                     flush_q, frame_done_q, frame_busy_q;
  logic [COUNT_WIDTH-1:0]   frame_rays_q;
  logic [COUNT_WIDTH-1:0]   accept_cnt_q, accept_cnt_d;
  logic [COUNT_WIDTH-1:0]   dispatch_cnt_q, dispatch_cnt_d;
  logic                     buf_full_q, buf_full_d;
  logic [RW-1:0]            buf_pos_q, buf_dir_q;
  logic [ADDRESS_WIDTH-1:0] buf_addr_q;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [N_UNITS-1:0]       grant_s;
  logic [IW-1:0]            grant_idx_s;
  logic                     grant_valid_s;
  logic                     run_s, issue_s, accept_s, frame_start_s;

  rr_arbiter #(.N(N_UNITS), .IW(IW)) u_arb (
    .req_i        (unitReady),
    .ptr_i        (rr_ptr_q),
    .grant_o      (grant_s),
    .grant_idx_o  (grant_idx_s),
    .grant_valid_o(grant_valid_s)
  );

  // Handshake, issue decision and next-state of counters, buffer flag and pointer.
  always_comb begin
    run_s         = (state_q == RUN);
    issue_s       = run_s && buf_full_q && grant_valid_s;
    // An issue frees the buffer in the same cycle, so a new ray can load behind it.
    rayReady      = run_s && (accept_cnt_q < frame_rays_q) && (!buf_full_q || issue_s);
    accept_s      = rayValid && rayReady;
    frame_start_s = (state_q == IDLE) && frameStart;

    if (issue_s) begin
      unitStart = grant_s;
    end else begin
      unitStart = '0;
    end

    accept_cnt_d   = accept_cnt_q;
    dispatch_cnt_d = dispatch_cnt_q;
    rr_ptr_d       = rr_ptr_q;
    if (frame_start_s) begin
      accept_cnt_d   = '0;
      dispatch_cnt_d = '0;
    end else begin
      if (accept_s) begin
        accept_cnt_d = accept_cnt_q + COUNT_WIDTH'(1);
      end else begin
        accept_cnt_d = accept_cnt_q;
      end
      if (issue_s) begin
        dispatch_cnt_d = dispatch_cnt_q + COUNT_WIDTH'(1);
        if (grant_idx_s == IW'(N_UNITS - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_idx_s + IW'(1);
        end
      end else begin
        dispatch_cnt_d = dispatch_cnt_q;
      end
    end

    if (accept_s) begin
      buf_full_d = 1'b1;
    end else if (issue_s) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end
  end

  // Datapath registers: counters, round-robin pointer and the one-entry ray buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accept_cnt_q   <= '0;
      dispatch_cnt_q <= '0;
      rr_ptr_q       <= '0;
      buf_full_q     <= 1'b0;
      buf_pos_q      <= '0;
      buf_dir_q      <= '0;
      buf_addr_q     <= '0;
    end else begin
      accept_cnt_q   <= accept_cnt_d;
      dispatch_cnt_q <= dispatch_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      buf_full_q     <= buf_full_d;
      if (accept_s) begin
        buf_pos_q  <= inRayQ;
        buf_dir_q  <= inRayV;
        buf_addr_q <= inPixelAddress;
      end else begin
        buf_pos_q  <= buf_pos_q;
        buf_dir_q  <= buf_dir_q;
        buf_addr_q <= buf_addr_q;
      end
    end
  end

  // Frame FSM with registered flush / done / busy outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      flush_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_rays_q <= '0;
    end else begin
      flush_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frameStart) begin
            frame_rays_q <= frameRays;
            if (frameRays == '0) begin
              frame_done_q <= 1'b1;
            end else begin
              state_q      <= FLUSH;
              flush_q      <= 1'b1;
              frame_busy_q <= 1'b1;
            end
          end
        end
        FLUSH: state_q <= RUN;
        RUN: begin
          // Leaving one cycle after the final start lets that unit's busy show up in DRAIN.
          if (issue_s && (dispatch_cnt_d == frame_rays_q)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (unitBusy == '0) begin
            frame_done_q <= 1'b1;
            frame_busy_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          frame_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign frameBusy     = frame_busy_q;
  assign frameDone     = frame_done_q;
  assign flush         = flush_q;
  assign rayQ          = buf_pos_q;
  assign rayV          = buf_dir_q;
  assign pixelAddress  = buf_addr_q;
  assign dispatchCount = dispatch_cnt_q;

endmodule
